// File: rtl/rps_match_referee_if.sv
// Move handshake and match status bundle between the player decoders,
// the referee and the score display.
interface rps_match_referee_if #(
  parameter int SCORE_W = 4,
  parameter int RND_W   = 4
);
  logic               start;
  logic               p1_valid;
  logic [1:0]         p1_move;
  logic               p2_valid;
  logic [1:0]         p2_move;
  logic               p1_ready;
  logic               p2_ready;
  logic               round_valid;
  logic [1:0]         round_result;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [RND_W-1:0]   round_cnt;
  logic               match_done;
  logic [1:0]         match_winner;

  modport master (
    output start, p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready, round_valid, round_result,
           p1_score, p2_score, round_cnt, match_done, match_winner
  );

  modport slave (
    input  start, p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready, round_valid, round_result,
           p1_score, p2_score, round_cnt, match_done, match_winner
  );
endinterface

// File: rtl/rps_match_referee.sv
// Rock-paper-scissors match referee: collects one move per player per round, scores it,
// and declares a winner at first-to-WIN_ROUNDS or at the MAX_ROUNDS cap.
module rps_match_referee #(
  parameter int WIN_ROUNDS  = 3,
  parameter int MAX_ROUNDS  = 9,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SCORE_W     = 4,
  parameter int RND_W       = 4,
  parameter int TMO_W       = 16
) (
  input logic                clk,
  input logic                rst,
  rps_match_referee_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MOVES, RESOLVE, DONE} state_t;
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_TIE  = 2'b11
  } result_t;

  localparam logic [1:0]         MV_FOUL  = 2'b11;
  localparam logic [SCORE_W-1:0] WIN_L    = SCORE_W'(WIN_ROUNDS);
  localparam logic [RND_W-1:0]   MAX_L    = RND_W'(MAX_ROUNDS);
  localparam bit                 TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic               p1_have_q, p2_have_q;
  logic [1:0]         p1_mv_q, p2_mv_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [SCORE_W-1:0] p1_score_q, p2_score_q;
  logic [RND_W-1:0]   round_cnt_q;
  result_t            round_result_q, match_winner_q;
  logic               round_valid_q;

  logic               p1_cap, p2_cap, timeout_hit;
  logic               p1_legal, p2_legal;
  result_t            outcome, final_winner;
  logic [SCORE_W-1:0] p1_score_nx, p2_score_nx;
  logic [RND_W-1:0]   round_cnt_nx;
  logic               win_reached, cap_reached;

  // The legal move that beats m (paper beats rock, scissors paper, rock scissors).
  function automatic logic [1:0] beater(input logic [1:0] m);
    return (m == 2'b10) ? 2'b00 : m + 2'b01;
  endfunction

  assign bus.p1_ready     = (state_q == WAIT_MOVES) && !p1_have_q;
  assign bus.p2_ready     = (state_q == WAIT_MOVES) && !p2_have_q;
  assign bus.round_valid  = round_valid_q;
  assign bus.round_result = round_result_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.round_cnt    = round_cnt_q;
  assign bus.match_done   = (state_q == DONE);
  assign bus.match_winner = match_winner_q;

  assign p1_cap      = bus.p1_ready && bus.p1_valid;
  assign p2_cap      = bus.p2_ready && bus.p2_valid;
  assign timeout_hit = TMO_EN && (p1_have_q ^ p2_have_q) && (tmo_q == TMO_LAST);

  // An absent (forfeited) move has no latch flag, so it scores exactly like a foul.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    outcome      = RES_TIE;
    final_winner = RES_TIE;
    p1_legal     = p1_have_q && (p1_mv_q != MV_FOUL);
    p2_legal     = p2_have_q && (p2_mv_q != MV_FOUL);
    if (p1_legal && p2_legal) begin
      if (p1_mv_q == p2_mv_q)              outcome = RES_TIE;
      else if (p1_mv_q == beater(p2_mv_q)) outcome = RES_P1;
      else                                 outcome = RES_P2;
    end else if (p1_legal) begin
      outcome = RES_P1;
    end else if (p2_legal) begin
      outcome = RES_P2;
    end
    p1_score_nx  = p1_score_q + SCORE_W'(outcome == RES_P1);
    p2_score_nx  = p2_score_q + SCORE_W'(outcome == RES_P2);
    round_cnt_nx = round_cnt_q + RND_W'(1);
    win_reached  = (p1_score_nx == WIN_L) || (p2_score_nx == WIN_L);
    cap_reached  = (round_cnt_nx == MAX_L);
    if (p1_score_nx == WIN_L)            final_winner = RES_P1;
    else if (p2_score_nx == WIN_L)       final_winner = RES_P2;
    else if (p1_score_nx > p2_score_nx)  final_winner = RES_P1;
    else if (p1_score_nx < p2_score_nx)  final_winner = RES_P2;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = WAIT_MOVES;
      WAIT_MOVES: begin
        if (((p1_have_q || p1_cap) && (p2_have_q || p2_cap)) || timeout_hit)
          state_d = RESOLVE;
      end
      RESOLVE:    state_d = (win_reached || cap_reached) ? DONE : WAIT_MOVES;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q        <= IDLE;
      p1_have_q      <= 1'b0;
      p2_have_q      <= 1'b0;
      p1_mv_q        <= '0;
      p2_mv_q        <= '0;
      tmo_q          <= '0;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      round_cnt_q    <= '0;
      round_result_q <= RES_NONE;
      match_winner_q <= RES_NONE;
      round_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_cnt_q    <= '0;
            round_result_q <= RES_NONE;
            match_winner_q <= RES_NONE;
          end
        end
        WAIT_MOVES: begin
          if (p1_cap) begin
            p1_have_q <= 1'b1;
            p1_mv_q   <= bus.p1_move;
          end
          if (p2_cap) begin
            p2_have_q <= 1'b1;
            p2_mv_q   <= bus.p2_move;
          end
          // The counter sits at 0 until the first capture, then runs while one side waits.
          if (TMO_EN && (p1_have_q ^ p2_have_q)) tmo_q <= tmo_q + TMO_W'(1);
        end
        RESOLVE: begin
          round_result_q <= outcome;
          p1_score_q     <= p1_score_nx;
          p2_score_q     <= p2_score_nx;
          round_cnt_q    <= round_cnt_nx;
          round_valid_q  <= 1'b1;
          p1_have_q      <= 1'b0;
          p2_have_q      <= 1'b0;
          tmo_q          <= '0;
          if (win_reached || cap_reached) match_winner_q <= final_winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_referee.sv
// Self-checking bench for rps_match_referee: directed and randomized rounds scored
// against a plain-arithmetic match model.
module tb_rps_match_referee;
  localparam int WIN_ROUNDS  = 3;
  localparam int MAX_ROUNDS  = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int SCORE_W     = 4;
  localparam int RND_W       = 4;
  localparam int TMO_W       = 16;
  localparam int ABSENT      = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Match model: results 1 = P1, 2 = P2, 3 = tie.
  int sc1, sc2, rounds, m_winner;
  bit m_done;

  rps_match_referee_if #(.SCORE_W(SCORE_W), .RND_W(RND_W)) bus ();

  rps_match_referee #(
    .WIN_ROUNDS (WIN_ROUNDS),
    .MAX_ROUNDS (MAX_ROUNDS),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SCORE_W    (SCORE_W),
    .RND_W      (RND_W),
    .TMO_W      (TMO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moves 0..2 legal, 3 foul, 4 absent (forfeit).
  function automatic int judge(input int a, input int b);
    bit la, lb;
    la = (a < 3);
    lb = (b < 3);
    if (la && lb) begin
      if (a == b) return 3;
      return (((a - b + 3) % 3) == 1) ? 1 : 2;
    end
    if (la) return 1;
    if (lb) return 2;
    return 3;
  endfunction

  task automatic model_apply(input int res);
    if (res == 1) sc1++;
    if (res == 2) sc2++;
    rounds++;
    if (sc1 == WIN_ROUNDS) begin
      m_done = 1; m_winner = 1;
    end else if (sc2 == WIN_ROUNDS) begin
      m_done = 1; m_winner = 2;
    end else if (rounds == MAX_ROUNDS) begin
      m_done   = 1;
      m_winner = (sc1 > sc2) ? 1 : (sc1 < sc2) ? 2 : 3;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p1_ready"},     32'(bus.p1_ready), 0);
    check({tag, "_p2_ready"},     32'(bus.p2_ready), 0);
    check({tag, "_round_valid"},  32'(bus.round_valid), 0);
    check({tag, "_round_result"}, 32'(bus.round_result), 0);
    check({tag, "_p1_score"},     32'(bus.p1_score), 0);
    check({tag, "_p2_score"},     32'(bus.p2_score), 0);
    check({tag, "_round_cnt"},    32'(bus.round_cnt), 0);
    check({tag, "_match_done"},   32'(bus.match_done), 0);
    check({tag, "_match_winner"}, 32'(bus.match_winner), 0);
  endtask

  task automatic do_reset(input bit start_too);
    rst       = 1'b1;
    bus.start = start_too;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    sc1 = 0; sc2 = 0; rounds = 0; m_done = 0; m_winner = 0;
    check_all_zero("reset");
  endtask

  task automatic start_match();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    sc1 = 0; sc2 = 0; rounds = 0; m_done = 0; m_winner = 0;
    check("start_p1_ready",   32'(bus.p1_ready), 1);
    check("start_p2_ready",   32'(bus.p2_ready), 1);
    check("start_p1_score",   32'(bus.p1_score), 0);
    check("start_p2_score",   32'(bus.p2_score), 0);
    check("start_round_cnt",  32'(bus.round_cnt), 0);
    check("start_result",     32'(bus.round_result), 0);
    check("start_match_done", 32'(bus.match_done), 0);
  endtask

  // Player x presents its move before edge dx; a move of ABSENT never shows up.
  task automatic play_round(input int m1, input int m2, input int d1, input int d2);
    bit c1, c2, g1, g2, p1_in, p2_in;
    int rv_edge, res;
    c1 = 0; c2 = 0;
    p1_in = (m1 != ABSENT);
    p2_in = (m2 != ABSENT);
    if (p1_in && p2_in) rv_edge = ((d1 > d2) ? d1 : d2) + 1;
    else                rv_edge = (p1_in ? d1 : d2) + TIMEOUT_CYC + 1;
    for (int t = 0; t <= rv_edge; t++) begin
      if (t == rv_edge) begin
        // Round is resolving: stray moves offered now must be ignored.
        check("resolve_p1_ready", 32'(bus.p1_ready), 0);
        check("resolve_p2_ready", 32'(bus.p2_ready), 0);
        g1 = 0; g2 = 0;
        bus.p1_valid = 1'($urandom_range(0, 1));
        bus.p2_valid = 1'($urandom_range(0, 1));
        bus.p1_move  = 2'($urandom_range(0, 3));
        bus.p2_move  = 2'($urandom_range(0, 3));
      end else begin
        check("wait_p1_ready", 32'(bus.p1_ready), 32'(!c1));
        check("wait_p2_ready", 32'(bus.p2_ready), 32'(!c2));
        g1 = !c1 && p1_in && (t >= d1);
        g2 = !c2 && p2_in && (t >= d2);
        bus.p1_valid = c1 ? 1'($urandom_range(0, 1)) : g1;
        bus.p2_valid = c2 ? 1'($urandom_range(0, 1)) : g2;
        bus.p1_move  = g1 ? 2'(m1) : 2'($urandom_range(0, 3));
        bus.p2_move  = g2 ? 2'(m2) : 2'($urandom_range(0, 3));
      end
      tick();
      c1 = c1 | g1;
      c2 = c2 | g2;
      if (t < rv_edge) check("round_valid_early", 32'(bus.round_valid), 0);
    end
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    res = judge(m1, m2);
    model_apply(res);
    check("round_valid",  32'(bus.round_valid), 1);
    check("round_result", 32'(bus.round_result), res);
    check("p1_score",     32'(bus.p1_score), sc1);
    check("p2_score",     32'(bus.p2_score), sc2);
    check("round_cnt",    32'(bus.round_cnt), rounds);
    check("match_done",   32'(bus.match_done), 32'(m_done));
    if (m_done) check("match_winner", 32'(bus.match_winner), m_winner);
    check("next_p1_ready", 32'(bus.p1_ready), 32'(!m_done));
    check("next_p2_ready", 32'(bus.p2_ready), 32'(!m_done));
  endtask

  // In DONE, outputs hold and offered moves are ignored.
  task automatic done_hold();
    for (int i = 0; i < 3; i++) begin
      bus.p1_valid = 1'b1;
      bus.p2_valid = 1'b1;
      bus.p1_move  = 2'($urandom_range(0, 3));
      bus.p2_move  = 2'($urandom_range(0, 3));
      tick();
      check("done_p1_ready",     32'(bus.p1_ready), 0);
      check("done_p2_ready",     32'(bus.p2_ready), 0);
      check("done_round_valid",  32'(bus.round_valid), 0);
      check("done_match_done",   32'(bus.match_done), 1);
      check("done_match_winner", 32'(bus.match_winner), m_winner);
      check("done_p1_score",     32'(bus.p1_score), sc1);
      check("done_p2_score",     32'(bus.p2_score), sc2);
      check("done_round_cnt",    32'(bus.round_cnt), rounds);
    end
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
  endtask

  initial begin
    int m1, m2, r;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    bus.p1_move  = 2'b00;
    bus.p2_move  = 2'b00;
    repeat (2) tick();
    do_reset(1'b0);

    // Match 1: rock beats scissors, start ignored mid-match, foul, double foul, timeout at the cap.
    start_match();
    play_round(0, 2, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("midmatch_start_p1_score",  32'(bus.p1_score), 1);
    check("midmatch_start_round_cnt", 32'(bus.round_cnt), 1);
    check("midmatch_start_p1_ready",  32'(bus.p1_ready), 1);
    play_round(3, 0, 1, 0);
    play_round(3, 3, 0, 2);
    play_round(1, ABSENT, 0, 0);
    done_hold();

    // Match 2: player 2 wins three straight.
    start_match();
    for (int i = 0; i < 3; i++) begin
      m2 = int'($urandom_range(0, 2));
      play_round((m2 + 2) % 3, m2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    done_hold();

    // Match 3: four ties reach the cap with a drawn match.
    start_match();
    for (int i = 0; i < 4; i++) begin
      m1 = int'($urandom_range(0, 3));
      play_round(m1, m1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    done_hold();

    // Randomized matches, including fouls and the occasional timeout.
    for (int k = 0; k < 8; k++) begin
      start_match();
      while (!m_done) begin
        m1 = int'($urandom_range(0, 3));
        m2 = int'($urandom_range(0, 3));
        r  = int'($urandom_range(0, 9));
        if (r == 0) m1 = ABSENT;
        else if (r == 1) m2 = ABSENT;
        play_round(m1, m2, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      end
    end
    done_hold();

    // Reset mid-round with one move latched, start raised alongside it.
    start_match();
    play_round(1, 0, 0, 0);
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b10;
    tick();
    bus.p1_valid = 1'b0;
    check("midround_p1_ready", 32'(bus.p1_ready), 0);
    tick();
    do_reset(1'b1);
    start_match();
    play_round(0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
